// File: rtl/data_sram_slave.sv
// ============================================================================
//  Module      : data_sram_slave
//  Description : SRAM-like data-side responder. Accepts req/addr handshakes,
//                performs the access on an internal word-addressed memory at
//                the accept edge and returns in-order data_ok/rdata after a
//                fixed LATENCY through a small ageing FIFO.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module data_sram_slave #(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 2,
  parameter int MAX_OUT = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        data_sram_req,
  input  logic        data_sram_wr,
  input  logic [1:0]  data_sram_size,
  input  logic [3:0]  data_sram_wstrb,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic        data_sram_addr_ok,
  output logic        data_sram_data_ok,
  output logic [31:0] data_sram_rdata,
  input  logic        stall_addr
);

  localparam int              c_PW       = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam int              c_DEPTH    = 1 << ADDR_W;
  localparam logic [c_PW:0]   c_MAX_OUT  = (c_PW + 1)'(MAX_OUT);
  localparam logic [c_PW:0]   c_PTR_ONE  = (c_PW + 1)'(1);
  localparam logic [3:0]      c_LAT      = 4'(LATENCY);

  // Reject parameter sets the queue/age logic cannot represent.
  if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
    $error("data_sram_slave: LATENCY must be in 1..15");
  end
  if (MAX_OUT < 2 || MAX_OUT > 16 || (MAX_OUT & (MAX_OUT - 1)) != 0) begin : g_bad_max_out
    $error("data_sram_slave: MAX_OUT must be a power of 2 in 2..16");
  end

  // Backing store (not reset) and response queue state.
  logic [31:0]        r_mem     [c_DEPTH];
  logic [MAX_OUT-1:0] r_valid;
  logic [MAX_OUT-1:0] r_is_load;
  logic [31:0]        r_data    [MAX_OUT];
  logic [3:0]         r_age     [MAX_OUT];
  logic [c_PW:0]      r_wr_ptr;
  logic [c_PW:0]      r_rd_ptr;
  logic [c_PW:0]      r_count;

  logic [ADDR_W-1:0]  w_idx;
  logic [c_PW-1:0]    w_head;
  logic [c_PW-1:0]    w_tail;
  logic [31:0]        w_rd_word;
  logic               w_retire;
  logic               w_accept;
  logic               w_unused;

  // Upper address bits alias; the low two bits select bytes outside this block.
  assign w_idx     = data_sram_addr[ADDR_W+1:2];
  assign w_head    = r_rd_ptr[c_PW-1:0];
  assign w_tail    = r_wr_ptr[c_PW-1:0];
  assign w_rd_word = r_mem[w_idx];

  // Head retires exactly when it has aged to LATENCY; at most one per cycle.
  assign w_retire  = r_valid[w_head] & (r_age[w_head] == c_LAT);

  // A full queue still admits one request in a cycle that frees a slot.
  assign data_sram_addr_ok = resetn & ~stall_addr & ((r_count < c_MAX_OUT) | w_retire);
  assign w_accept          = data_sram_req & data_sram_addr_ok;

  assign data_sram_data_ok = w_retire;
  assign data_sram_rdata   = (w_retire & r_is_load[w_head]) ? r_data[w_head] : 32'h0;

  assign w_unused = ^{data_sram_size, data_sram_addr[31:ADDR_W+2], data_sram_addr[1:0]};

  // Byte-masked store into the word array at the accept edge.
  always_ff @(posedge clk) begin
    if (w_accept && data_sram_wr) begin
      for (int b = 0; b < 4; b++) begin
        if (data_sram_wstrb[b]) begin
          r_mem[w_idx][8*b +: 8] <= data_sram_wdata[8*b +: 8];
        end
      end
    end
  end

  // Response queue: age entries, retire the head, push accepted requests.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_valid   <= '0;
      r_is_load <= '0;
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      for (int i = 0; i < MAX_OUT; i++) begin
        r_data[i] <= '0;
        r_age[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < MAX_OUT; i++) begin
        if (r_valid[i] && (r_age[i] != c_LAT)) begin
          r_age[i] <= r_age[i] + 4'd1;
        end
      end
      if (w_retire) begin
        r_valid[w_head] <= 1'b0;
        r_rd_ptr        <= r_rd_ptr + c_PTR_ONE;
      end
      // Push comes last so it wins when the tail slot is the retiring head.
      if (w_accept) begin
        r_valid[w_tail]   <= 1'b1;
        r_is_load[w_tail] <= ~data_sram_wr;
        r_data[w_tail]    <= w_rd_word;
        r_age[w_tail]     <= 4'd1;
        r_wr_ptr          <= r_wr_ptr + c_PTR_ONE;
      end
      case ({w_accept, w_retire})
        2'b10:   r_count <= r_count + c_PTR_ONE;
        2'b01:   r_count <= r_count - c_PTR_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

`default_nettype wire
